// File: rtl/dmem_pkg.sv
// dmem_pkg: access sizes, arbiter FSM states and the alignment rule shared by the data-memory arbiter.
package dmem_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;
  // Size 11 falls through every term and is therefore always misaligned.
  function automatic logic aligned(input logic [1:0] size, input logic [1:0] lo);
    return size == SIZE_BYTE || (size == SIZE_HALF && !lo[0]) || (size == SIZE_WORD && lo == 2'b00);
  endfunction
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester's req/ack handshake and load/store bus into the data-memory arbiter.
interface dmem_arbiter_if #(parameter int ADDR_W = 9) ();
  logic req;
  logic we;
  logic [1:0] size;
  logic [ADDR_W-1:0] addr;
  logic [31:0] wdata;
  logic ack;
  logic err;
  logic [31:0] rdata;
  modport master (output req, we, size, addr, wdata, input ack, err, rdata);
  modport slave (input req, we, size, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: extracts a byte/half/word from a memory word by lane and zero-extends it.
module dmem_lane_align import dmem_pkg::*; (
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);
  assign data_o = size_i == SIZE_BYTE ? {24'd0, word_i[8*lane_i +: 8]} :
                  size_i == SIZE_HALF ? {16'd0, lane_i[1] ? word_i[31:16] : word_i[15:0]} : word_i;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of the single-port data memory between CPU (port 0) and loader (port 1).
module dmem_arbiter import dmem_pkg::*; #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_arbiter_if.slave     p0,
  dmem_arbiter_if.slave     p1,
  output logic              mem_we,
  output logic              mem_re,
  output logic              mem_sub,
  output logic              mem_half,
  output logic [1:0]        mem_lane,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_e state_q, state_d;
  logic rr_q, rr_d, gnt_q, gnt_d, we_q, we_d, err_q, err_d;
  logic [1:0] size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d, load_word;
  logic ok, in_acc, win;

  dmem_lane_align u_align (.size_i(size_q), .lane_i(addr_q[1:0]), .word_i(mem_rdata), .data_o(load_word));

  // Memory controls decode only registered state, so an async reset kills mem_we at once.
  assign ok = aligned(size_q, addr_q[1:0]);
  assign in_acc = state_q == ST_ACCESS && ok;
  assign mem_we = in_acc && we_q;
  assign mem_re = in_acc && !we_q;
  assign mem_sub = mem_we && size_q != SIZE_WORD;
  assign mem_half = mem_sub && size_q == SIZE_HALF;
  assign mem_lane = addr_q[1:0];
  assign mem_addr = addr_q[ADDR_W-1:2];
  assign mem_wdata = wdata_q;
  assign win = p0.req && p1.req ? rr_q : p1.req;
  assign p0.ack = state_q == ST_RESP && !gnt_q;
  assign p1.ack = state_q == ST_RESP && gnt_q;
  assign p0.err = p0.ack && err_q;
  assign p1.err = p1.ack && err_q;
  assign p0.rdata = rdata_q;
  assign p1.rdata = rdata_q;

  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    gnt_d = gnt_q;
    we_d = we_q;
    size_d = size_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    err_d = err_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: if (p0.req || p1.req) begin
        state_d = ST_ACCESS;
        gnt_d = win;
        rr_d = !win;
        we_d = win ? p1.we : p0.we;
        size_d = win ? p1.size : p0.size;
        addr_d = win ? p1.addr : p0.addr;
        wdata_d = win ? p1.wdata : p0.wdata;
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        err_d = !ok;
        rdata_d = mem_re ? load_word : rdata_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rr_q <= 1'b0;
      gnt_q <= 1'b0;
      we_q <= 1'b0;
      size_q <= SIZE_BYTE;
      addr_q <= '0;
      wdata_q <= '0;
      err_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      gnt_q <= gnt_d;
      we_q <= we_d;
      size_q <= size_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table plus corner-case sequences against a behavioural memory and ack scoreboard.
module tb_dmem_arbiter;
  import dmem_pkg::*;
  typedef struct {bit port; bit we; logic [1:0] size; logic [8:0] addr; logic [31:0] wdata; bit err; logic [31:0] rdata;} vec_t;
  typedef struct {bit port; bit err; bit chk_rd; logic [31:0] rdata;} exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_we, mem_re, mem_sub, mem_half;
  logic [1:0] mem_lane;
  logic [6:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] mem [128];
  exp_t sb[$];
  exp_t mon_e;
  int ack_cyc[$];
  int cyc = 0;
  int n_acc = 0;
  int checks = 0;
  int fails = 0;
  vec_t vt[12];

  always #5 clk = ~clk;

  dmem_arbiter_if p0();
  dmem_arbiter_if p1();

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .p0(p0), .p1(p1),
    .mem_we(mem_we), .mem_re(mem_re), .mem_sub(mem_sub), .mem_half(mem_half),
    .mem_lane(mem_lane), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk)
    if (mem_we) begin
      if (!mem_sub) mem[mem_addr] <= mem_wdata;
      else if (mem_half) mem[mem_addr][16*mem_lane[1] +: 16] <= mem_wdata[15:0];
      else mem[mem_addr][8*mem_lane +: 8] <= mem_wdata[7:0];
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mem_we || mem_re) n_acc++;
    if (p0.ack || p1.ack) begin
      ack_cyc.push_back(cyc);
      chk("ack_exclusive", {31'd0, p0.ack & p1.ack}, 32'd0);
      if (sb.size() == 0) chk("unexpected_ack", {30'd0, p1.ack, p0.ack}, 32'd0);
      else begin
        mon_e = sb.pop_front();
        chk("ack_port", {31'd0, p1.ack}, {31'd0, mon_e.port});
        chk("err", {31'd0, p1.ack ? p1.err : p0.err}, {31'd0, mon_e.err});
        if (mon_e.chk_rd) chk("rdata", p1.ack ? p1.rdata : p0.rdata, mon_e.rdata);
      end
    end
  end

  task automatic drive(input bit p, input bit r, input vec_t v);
    if (p) begin
      p1.req = r; p1.we = v.we; p1.size = v.size; p1.addr = v.addr; p1.wdata = v.wdata;
    end else begin
      p0.req = r; p0.we = v.we; p0.size = v.size; p0.addr = v.addr; p0.wdata = v.wdata;
    end
  endtask

  task automatic expect_txn(input vec_t v);
    sb.push_back('{v.port, v.err, !v.we && !v.err, v.rdata});
  endtask

  task automatic txn(input vec_t v);
    int n = 0;
    expect_txn(v);
    @(posedge clk); #1 drive(v.port, 1'b1, v);
    do begin
      @(negedge clk);
      n++;
    end while (!(v.port ? p1.ack : p0.ack) && n < 10);
    chk("ack_latency", n, 3);
    @(posedge clk); #1 drive(v.port, 1'b0, v);
  endtask

  task automatic wait_acks(input int target);
    int n = 0;
    while (ack_cyc.size() < target && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    chk("ack_count", ack_cyc.size(), target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v0, v1;
    int pre, base;
    logic [31:0] w4, wpre;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[2] = 32'h55667788;
    mem[3] = 32'hA1B2C3D4;
    mem[4] = 32'h11223344;
    v0 = '{0, 0, SIZE_WORD, 9'h000, 32'h0, 0, 32'h0};
    drive(0, 1'b0, v0);
    drive(1, 1'b0, v0);
    vt[0]  = '{0, 0, SIZE_WORD, 9'h00C, 32'h0,      0, 32'hA1B2C3D4};
    vt[1]  = '{0, 1, SIZE_BYTE, 9'h00E, 32'h0000005A, 0, 32'h0};
    vt[2]  = '{0, 0, SIZE_WORD, 9'h00C, 32'h0,      0, 32'hA15AC3D4};
    vt[3]  = '{0, 0, SIZE_HALF, 9'h00E, 32'h0,      0, 32'h0000A15A};
    vt[4]  = '{0, 0, SIZE_BYTE, 9'h00D, 32'h0,      0, 32'h000000C3};
    vt[5]  = '{1, 0, SIZE_HALF, 9'h00C, 32'h0,      0, 32'h0000C3D4};
    vt[6]  = '{1, 1, SIZE_HALF, 9'h012, 32'h0000BEEF, 0, 32'h0};
    vt[7]  = '{1, 0, SIZE_WORD, 9'h010, 32'h0,      0, 32'hBEEF3344};
    vt[8]  = '{0, 0, SIZE_WORD, 9'h006, 32'h0,      1, 32'h0};
    vt[9]  = '{1, 1, SIZE_HALF, 9'h009, 32'h0000CAFE, 1, 32'h0};
    vt[10] = '{0, 0, 2'b11,     9'h000, 32'h0,      1, 32'h0};
    vt[11] = '{1, 0, SIZE_BYTE, 9'h013, 32'h0,      0, 32'h000000BE};

    #12;
    chk("rst_acks", {28'd0, p0.ack, p1.ack, p0.err, p1.err}, 32'd0);
    chk("rst_rdata0", p0.rdata, 32'd0);
    chk("rst_rdata1", p1.rdata, 32'd0);
    chk("rst_mem_ctl", {26'd0, mem_we, mem_re, mem_sub, mem_half, mem_lane}, 32'd0);
    chk("rst_mem_addr", {25'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      pre = n_acc;
      wpre = mem[vt[i].addr[8:2]];
      txn(vt[i]);
      if (vt[i].err) begin
        chk("misalign_no_access", pre, n_acc);
        chk("misalign_mem_kept", mem[vt[i].addr[8:2]], wpre);
      end
    end
    chk("mem_word3", mem[3], 32'hA15AC3D4);
    chk("mem_word4", mem[4], 32'hBEEF3344);

    // Contention from reset: both ports hold req for four grants.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    v0 = '{0, 0, SIZE_WORD, 9'h00C, 32'h0, 0, 32'hA15AC3D4};
    v1 = '{1, 0, SIZE_WORD, 9'h010, 32'h0, 0, 32'hBEEF3344};
    for (int k = 0; k < 2; k++) begin expect_txn(v0); expect_txn(v1); end
    base = ack_cyc.size();
    @(posedge clk); #1 drive(0, 1'b1, v0); drive(1, 1'b1, v1);
    wait_acks(base + 4);
    @(posedge clk); #1 drive(0, 1'b0, v0); drive(1, 1'b0, v1);
    for (int k = 1; k < 4; k++)
      if (ack_cyc.size() > base + k) chk("ack_spacing", ack_cyc[base+k] - ack_cyc[base+k-1], 3);

    // Reset in ACCESS of a port 1 word store.
    w4 = mem[4];
    v1 = '{1, 1, SIZE_WORD, 9'h010, 32'hDEADBEEF, 0, 32'h0};
    base = ack_cyc.size();
    @(posedge clk); #1 drive(1, 1'b1, v1);
    @(posedge clk); #2 chk("access_we", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1 chk("rst_we_drop", {31'd0, mem_we}, 32'd0);
    drive(1, 1'b0, v1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_no_ack", ack_cyc.size(), base);
    chk("rst_no_store", mem[4], w4);
    v0 = '{0, 0, SIZE_WORD, 9'h010, 32'h0, 0, w4};
    v1 = '{1, 0, SIZE_WORD, 9'h010, 32'h0, 0, w4};
    expect_txn(v0); expect_txn(v1);
    @(posedge clk); #1 drive(0, 1'b1, v0); drive(1, 1'b1, v1);
    wait_acks(base + 2);
    @(posedge clk); #1 drive(0, 1'b0, v0); drive(1, 1'b0, v1);

    // Late arrival: req1 rises while port 0 is in ACCESS.
    v0 = '{0, 0, SIZE_WORD, 9'h00C, 32'h0, 0, 32'hA15AC3D4};
    v1 = '{1, 0, SIZE_BYTE, 9'h010, 32'h0, 0, {24'd0, w4[7:0]}};
    expect_txn(v0); expect_txn(v1);
    base = ack_cyc.size();
    @(posedge clk); #1 drive(0, 1'b1, v0);
    @(posedge clk); #1 drive(1, 1'b1, v1);
    wait_acks(base + 1);
    @(posedge clk); #1 drive(0, 1'b0, v0);
    wait_acks(base + 2);
    @(posedge clk); #1 drive(1, 1'b0, v1);
    if (ack_cyc.size() >= base + 2) chk("late_ack_gap", ack_cyc[base+1] - ack_cyc[base], 3);

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
